// File: rtl/gs_pkg.sv
// rtl/gs_pkg.sv - shared types and range check for the constant-cache loader
package gs_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} gs_ld_state_t;

  // A load is out of range when base + count runs past the end of the cache.
  function automatic logic range_err(input logic [31:0] base, input logic [31:0] count,
                                     input int unsigned aw);
    logic [32:0] sum;
    sum = {1'b0, base} + {1'b0, count};
    return sum > (33'd1 << aw);
  endfunction

endpackage

// File: rtl/gs_const_loader.sv
// rtl/gs_const_loader.sv - streams constant words into the per-MP constant cache
module gs_const_loader
  import gs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  cwe_gs,
  output logic [ADDR_WIDTH-1:0] caddr_gs,
  output logic [DATA_WIDTH-1:0] cdata_gs,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  const_valid
);

  gs_ld_state_t state, state_next;
  logic [ADDR_WIDTH-1:0] ptr, ptr_next;
  logic [CNT_WIDTH-1:0]  rem, rem_next;
  logic                  cwe_next, done_next, err_next, cv_next, busy_next;
  logic [ADDR_WIDTH-1:0] caddr_next;
  logic [DATA_WIDTH-1:0] cdata_next;

  assign in_ready = (state == LOAD) && !abort;

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    rem_next   = rem;
    cwe_next   = 1'b0;
    caddr_next = caddr_gs;
    cdata_next = cdata_gs;
    done_next  = 1'b0;
    err_next   = 1'b0;
    cv_next    = const_valid;
    case (state)
      IDLE: begin
        if (start) begin
          if (range_err(32'(base_addr), 32'(word_count), ADDR_WIDTH)) begin
            err_next = 1'b1;
          end else if (word_count == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
            cv_next    = 1'b1;
          end else begin
            state_next = LOAD;
            ptr_next   = base_addr;
            rem_next   = word_count;
            cv_next    = 1'b0;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (in_valid) begin
          cwe_next   = 1'b1;
          caddr_next = ptr;
          cdata_next = in_data;
          ptr_next   = ptr + 1'b1;
          rem_next   = rem - 1'b1;
          if (rem == CNT_WIDTH'(1)) state_next = DRAIN;
        end
      end
      // Final write is on the cache port this cycle; it has landed by DONE.
      DRAIN: begin
        state_next = DONE;
        done_next  = 1'b1;
        cv_next    = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == LOAD) || (state_next == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      rem         <= '0;
      cwe_gs      <= 1'b0;
      caddr_gs    <= '0;
      cdata_gs    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      const_valid <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      rem         <= rem_next;
      cwe_gs      <= cwe_next;
      caddr_gs    <= caddr_next;
      cdata_gs    <= cdata_next;
      busy        <= busy_next;
      done        <= done_next;
      err         <= err_next;
      const_valid <= cv_next;
    end
  end

endmodule
